seg_execute_pipe: RTL and testbench

//  MIPS EX stage with integrated EX/MEM pipeline register. Forwarding operand muxes, ALU, signed

---
 rtl/ex_pkg.sv | 38 +++
 rtl/ex_muldiv_unit.sv | 135 +++++++++++++
 rtl/seg_execute_pipe.sv | 159 +++++++++++++++
 tb/tb_seg_execute_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: ALU op codes, forwarding select
// codes and the multi-cycle unit state encoding.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_ADDU  = 5'h01,
    OP_SUB   = 5'h02,
    OP_SUBU  = 5'h03,
    OP_AND   = 5'h04,
    OP_OR    = 5'h05,
    OP_XOR   = 5'h06,
    OP_NOR   = 5'h07,
    OP_SLT   = 5'h08,
    OP_SLTU  = 5'h09,
    OP_SLL   = 5'h0A,
    OP_SRL   = 5'h0B,
    OP_SRA   = 5'h0C,
    OP_LUI   = 5'h0D,
    OP_MULT  = 5'h0E,
    OP_MULTU = 5'h0F,
    OP_MFHI  = 5'h10,
    OP_MFLO  = 5'h11,
    OP_DIV   = 5'h12,
    OP_DIVU  = 5'h13
  } alu_op_e;

  // Operand source selects; code 2'b11 falls back to the register value.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO unit: one shift-add multiply step (or one restoring
// division step when EX_DIV_EN is defined) per RUN cycle, NB_DATA steps.
// Operands are converted to magnitudes at start and the sign is fixed up
// on the final step, so HI/LO change only at the edge that leaves RUN.
// `state` is exposed so the parent can derive busy and checkers can bind.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         op,
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  output ex_state_e          state,
  output logic [NB_DATA-1:0] hi,
  output logic [NB_DATA-1:0] lo
);

  localparam int CW  = $clog2(NB_DATA);
  localparam int MSB = NB_DATA - 1;

  ex_state_e            state_next;
  logic [CW-1:0]        cnt;
  logic [NB_DATA-1:0]   acc_hi, acc_lo, mcand;
  logic                 neg_lo;
  logic                 is_signed, a_neg, b_neg, last;
  logic [NB_DATA-1:0]   a_mag, b_mag, step_hi, step_lo;
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_prod;
`ifdef EX_DIV_EN
  logic                 is_div, div_op, div_zero, div_ge, neg_hi;
  logic [NB_DATA:0]     div_shift;
`endif

  assign last = (cnt == CW'(NB_DATA - 1));

  // Operand sign detection and magnitude conversion at start.
  always_comb begin
    is_signed = (op == OP_MULT);
`ifdef EX_DIV_EN
    is_signed = is_signed | (op == OP_DIV);
    div_op    = (op == OP_DIV) | (op == OP_DIVU);
`endif
    a_neg = is_signed & a[MSB];
    b_neg = is_signed & b[MSB];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: IDLE -> RUN on start, RUN -> IDLE after the last step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // One iteration step; mul_prod is the sign-corrected final product.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    step_hi = mul_sum[NB_DATA:1];
    step_lo = {mul_sum[0], acc_lo[MSB:1]};
`ifdef EX_DIV_EN
    div_shift = {acc_hi, acc_lo[MSB]};
    div_ge    = (div_shift >= {1'b0, mcand});
    if (is_div) begin
      // The difference always fits NB_DATA bits because it is below mcand.
      step_hi = div_ge ? (div_shift[MSB:0] - mcand) : div_shift[MSB:0];
      step_lo = {acc_lo[MSB-1:0], div_ge};
    end
`endif
    mul_prod = {step_hi, step_lo};
    if (neg_lo) mul_prod = -mul_prod;
  end

  // Datapath: load magnitudes at start, iterate in RUN, commit HI/LO on last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef EX_DIV_EN
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      if (start) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= a_mag;
        mcand  <= b_mag;
        neg_lo <= a_neg ^ b_neg;
`ifdef EX_DIV_EN
        is_div   <= div_op;
        div_zero <= (b == '0);
        neg_hi   <= a_neg;
`endif
      end
    end else begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + 1'b1;
      if (last) begin
`ifdef EX_DIV_EN
        if (is_div) begin
          // Divide by zero: quotient all ones, remainder reproduces the dividend.
          lo <= div_zero ? '1 : (neg_lo ? -step_lo : step_lo);
          hi <= neg_hi ? -step_hi : step_hi;
        end else begin
          {hi, lo} <= mul_prod;
        end
`else
        {hi, lo} <= mul_prod;
`endif
      end
    end
  end

endmodule

// File: rtl/seg_execute_pipe.sv
// MIPS EX stage with integrated EX/MEM register: forwarding muxes, ALU with
// signed overflow detection and an iterative HI/LO multiply unit.
// Optional feature macro: EX_DIV_EN adds iterative DIV/DIVU.
//
// Handshake: an instruction is consumed when i_valid & ~o_busy & ~i_stall &
// ~i_flush. EX/MEM update priority is reset > flush (bubble) > stall (hold)
// > consumed single-cycle op (load) > anything else (bubble). A consumed
// multi-cycle op loads a bubble and raises o_busy for NB_DATA cycles.
module seg_execute_pipe
  import ex_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CTRL_WB  = 2,
  parameter int NB_CTRL_M   = 3,
  parameter int NB_ALU_OP   = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [NB_DATA-1:0]     i_pc,
  input  logic [NB_DATA-1:0]     i_rs_data,
  input  logic [NB_DATA-1:0]     i_rt_data,
  input  logic [NB_DATA-1:0]     i_imm,
  input  logic [4:0]             i_shamt,
  input  logic [NB_REG_ADDR-1:0] i_rt,
  input  logic [NB_REG_ADDR-1:0] i_rd,
  input  logic [NB_ALU_OP-1:0]   i_alu_op,
  input  logic                   i_alu_src,
  input  logic                   i_reg_dst,
  input  logic [1:0]             i_fwd_a_sel,
  input  logic [1:0]             i_fwd_b_sel,
  input  logic [NB_DATA-1:0]     i_mem_fwd_data,
  input  logic [NB_DATA-1:0]     i_wb_fwd_data,
  input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb,
  input  logic [NB_CTRL_M-1:0]   i_ctrl_m,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [NB_DATA-1:0]     o_pc,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic                   o_alu_zero,
  output logic                   o_overflow,
  output logic [NB_DATA-1:0]     o_store_data,
  output logic [NB_REG_ADDR-1:0] o_wr_reg,
  output logic [NB_CTRL_WB-1:0]  o_ctrl_wb,
  output logic [NB_CTRL_M-1:0]   o_ctrl_m
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] op_a, rt_fwd, op_b, sum, diff, alu_res, hi, lo;
  logic               alu_ovf, is_single, is_md, accept, load, md_start;
  ex_state_e          mdu_state;

  // Forwarding muxes; store data always takes the forwarded rt value.
  always_comb begin
    if (i_fwd_a_sel == FWD_MEM)     op_a = i_mem_fwd_data;
    else if (i_fwd_a_sel == FWD_WB) op_a = i_wb_fwd_data;
    else                            op_a = i_rs_data;
    if (i_fwd_b_sel == FWD_MEM)     rt_fwd = i_mem_fwd_data;
    else if (i_fwd_b_sel == FWD_WB) rt_fwd = i_wb_fwd_data;
    else                            rt_fwd = i_rt_data;
    op_b = i_alu_src ? i_imm : rt_fwd;
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // ALU result, signed overflow and op classification.
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    is_single = 1'b1;
    is_md     = 1'b0;
    case (i_alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_SUBU:  alu_res = diff;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOR:   alu_res = ~(op_a | op_b);
      OP_SLT:   alu_res = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(NB_DATA-1){1'b0}}, (op_a < op_b)};
      OP_SLL:   alu_res = op_b << i_shamt;
      OP_SRL:   alu_res = op_b >> i_shamt;
      OP_SRA:   alu_res = $unsigned($signed(op_b) >>> i_shamt);
      OP_LUI:   alu_res = op_b << 16;
      OP_MFHI:  alu_res = hi;
      OP_MFLO:  alu_res = lo;
      OP_MULT, OP_MULTU: begin
        is_single = 1'b0;
        is_md     = 1'b1;
      end
`ifdef EX_DIV_EN
      OP_DIV, OP_DIVU: begin
        is_single = 1'b0;
        is_md     = 1'b1;
      end
`endif
      default: is_single = 1'b0;
    endcase
  end

  assign o_busy   = (mdu_state == ST_RUN);
  assign accept   = i_valid & ~o_busy & ~i_stall & ~i_flush;
  assign load     = accept & is_single;
  assign md_start = accept & is_md;

  // EX/MEM register: flush/idle load a bubble, stall holds, accepted op loads.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || (!i_stall && !load)) begin
      o_valid      <= 1'b0;
      o_pc         <= '0;
      o_alu_result <= '0;
      o_alu_zero   <= 1'b0;
      o_overflow   <= 1'b0;
      o_store_data <= '0;
      o_wr_reg     <= '0;
      o_ctrl_wb    <= '0;
      o_ctrl_m     <= '0;
    end else if (load) begin
      o_valid      <= 1'b1;
      o_pc         <= i_pc;
      o_alu_result <= alu_res;
      o_alu_zero   <= (alu_res == '0);
      o_overflow   <= alu_ovf;
      o_store_data <= rt_fwd;
      o_wr_reg     <= i_reg_dst ? i_rd : i_rt;
      // An overflowing ADD/SUB must not write the register file.
      o_ctrl_wb    <= i_ctrl_wb & ~NB_CTRL_WB'(alu_ovf);
      o_ctrl_m     <= i_ctrl_m;
    end
  end

  ex_muldiv_unit #(
    .NB_DATA(NB_DATA)
  ) u_muldiv (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (md_start),
    .op    (i_alu_op[4:0]),
    .a     (op_a),
    .b     (op_b),
    .state (mdu_state),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_seg_execute_pipe.sv
// Bench for seg_execute_pipe: directed corner cases followed by randomized
// single-cycle and HI/LO traffic, checked against a behavioural model.
module tb_seg_execute_pipe;
  import ex_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic [2:0]  m;
  } exout_t;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_stall, i_flush, i_alu_src, i_reg_dst;
  logic [31:0] i_pc, i_rs_data, i_rt_data, i_imm, i_mem_fwd_data, i_wb_fwd_data;
  logic [4:0]  i_shamt, i_rt, i_rd, i_alu_op;
  logic [1:0]  i_fwd_a_sel, i_fwd_b_sel, i_ctrl_wb;
  logic [2:0]  i_ctrl_m;
  logic        o_busy, o_valid, o_alu_zero, o_overflow;
  logic [31:0] o_pc, o_alu_result, o_store_data;
  logic [4:0]  o_wr_reg;
  logic [1:0]  o_ctrl_wb;
  logic [2:0]  o_ctrl_m;

  exout_t      obs;
  exout_t      cur;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [127:0] exp_q[$];

  assign obs = {o_valid, o_pc, o_alu_result, o_alu_zero, o_overflow,
                o_store_data, o_wr_reg, o_ctrl_wb, o_ctrl_m};

  seg_execute_pipe dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_pc(i_pc), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_shamt(i_shamt), .i_rt(i_rt), .i_rd(i_rd),
    .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst),
    .i_fwd_a_sel(i_fwd_a_sel), .i_fwd_b_sel(i_fwd_b_sel),
    .i_mem_fwd_data(i_mem_fwd_data), .i_wb_fwd_data(i_wb_fwd_data),
    .i_ctrl_wb(i_ctrl_wb), .i_ctrl_m(i_ctrl_m), .o_busy(o_busy),
    .o_valid(o_valid), .o_pc(o_pc), .o_alu_result(o_alu_result),
    .o_alu_zero(o_alu_zero), .o_overflow(o_overflow), .o_store_data(o_store_data),
    .o_wr_reg(o_wr_reg), .o_ctrl_wb(o_ctrl_wb), .o_ctrl_m(o_ctrl_m)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    i_valid = 0; i_stall = 0; i_flush = 0; i_alu_src = 0; i_reg_dst = 0;
    i_pc = '0; i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_shamt = '0;
    i_rt = '0; i_rd = '0; i_alu_op = '0; i_fwd_a_sel = '0; i_fwd_b_sel = '0;
    i_mem_fwd_data = '0; i_wb_fwd_data = '0; i_ctrl_wb = '0; i_ctrl_m = '0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    i_valid = 1; i_alu_op = op; i_rs_data = a; i_rt_data = b; i_pc = 32'h400;
    i_rt = 5'd3; i_rd = 5'd9; i_reg_dst = 1; i_ctrl_wb = 2'b11; i_ctrl_m = 3'b101;
  endtask

  task automatic read_hilo(input logic [31:0] want_hi, input logic [31:0] want_lo);
    issue(OP_MFHI, '0, '0);
    tick();
    chk("mfhi", 128'(o_alu_result), 128'(want_hi));
    issue(OP_MFLO, '0, '0);
    tick();
    chk("mflo", 128'(o_alu_result), 128'(want_lo));
    idle();
  endtask

  // Start a HI/LO op, keep another instruction pending, count busy cycles.
  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic stall_run, input int flush_at);
    int n;
    issue(op, a, b);
    tick();
    chk("md_accept_bubble", 128'(obs), 128'(0));
    chk("md_busy_rise", 128'(o_busy), 128'(1));
    i_alu_op = OP_ADD;
    i_stall = stall_run;
    n = 0;
    while (o_busy && n < 100) begin
      i_flush = (n == flush_at);
      tick();
      n++;
      chk("md_input_held", 128'(obs), 128'(0));
    end
    chk("md_busy_cycles", 128'(n), 128'(32));
    idle();
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_single_op(input logic [4:0] op);
    return (op <= OP_LUI) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh,
                                          output logic ov);
    logic [31:0] r;
    longint wide;
    ov = 0;
    r = '0;
    case (op)
      OP_ADD: begin
        r = a + b;
        wide = longint'($signed(a)) + longint'($signed(b));
        ov = (wide != longint'($signed(r)));
      end
      OP_ADDU: r = a + b;
      OP_SUB: begin
        r = a - b;
        wide = longint'($signed(a)) - longint'($signed(b));
        ov = (wide != longint'($signed(r)));
      end
      OP_SUBU: r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA: begin
        wide = longint'($signed(b)) >>> sh;
        r = wide[31:0];
      end
      OP_LUI:  r = {b[15:0], 16'h0000};
      OP_MFHI: r = hi_m;
      OP_MFLO: r = lo_m;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exout_t model_single();
    exout_t e;
    logic [31:0] a, rtv, b, r;
    logic ov;
    e = '0;
    if (!is_single_op(i_alu_op)) return e;
    a   = (i_fwd_a_sel == 2'b01) ? i_mem_fwd_data : (i_fwd_a_sel == 2'b10) ? i_wb_fwd_data : i_rs_data;
    rtv = (i_fwd_b_sel == 2'b01) ? i_mem_fwd_data : (i_fwd_b_sel == 2'b10) ? i_wb_fwd_data : i_rt_data;
    b   = i_alu_src ? i_imm : rtv;
    r   = alu_ref(i_alu_op, a, b, i_shamt, ov);
    e.valid = 1; e.pc = i_pc; e.res = r; e.zero = (r == 0); e.ovf = ov; e.sd = rtv;
    e.wr = i_reg_dst ? i_rd : i_rt;
    e.wb = ov ? {i_ctrl_wb[1], 1'b0} : i_ctrl_wb;
    e.m = i_ctrl_m;
    return e;
  endfunction

  task automatic md_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp, q, r;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {hi_m, lo_m} = up;
      end
      OP_DIV: begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    i_rst = 1;
    tick();
    tick();
    chk("reset_exmem", 128'(obs), 128'(0));
    chk("reset_busy", 128'(o_busy), 128'(0));
    i_rst = 0;
    read_hilo(32'h0, 32'h0);

    // Signed overflow on ADD suppresses reg_write; ADDU never flags.
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    tick();
    chk("add_ovf_flag", 128'(o_overflow), 128'(1));
    chk("add_ovf_wb", 128'(o_ctrl_wb), 128'(2'b10));
    chk("add_ovf_res", 128'(o_alu_result), 128'(32'h8000_0000));
    chk("add_ovf_valid", 128'(o_valid), 128'(1));
    issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1);
    tick();
    chk("addu_res", 128'(o_alu_result), 128'(32'h8000_0000));
    chk("addu_flag", 128'(o_overflow), 128'(0));
    chk("addu_wb", 128'(o_ctrl_wb), 128'(2'b11));

    // MEM forwarding on A; zero flag.
    issue(OP_SUB, 32'h99, 32'h5);
    i_fwd_a_sel = 2'b01; i_mem_fwd_data = 32'h5;
    tick();
    chk("sub_fwd_res", 128'(o_alu_result), 128'(0));
    chk("sub_fwd_zero", 128'(o_alu_zero), 128'(1));

    // Immediate B with WB-forwarded store data.
    issue(OP_ADDU, 32'd10, 32'h1111);
    i_alu_src = 1; i_imm = 32'd20; i_fwd_b_sel = 2'b10; i_wb_fwd_data = 32'hDEAD_BEEF;
    tick();
    chk("imm_res", 128'(o_alu_result), 128'(32'd30));
    chk("imm_store", 128'(o_store_data), 128'(32'hDEAD_BEEF));
    chk("imm_wr_reg", 128'(o_wr_reg), 128'(5'd9));

    // Stall holds, stall+flush bubbles, no valid bubbles.
    issue(OP_ADDU, 32'd1, 32'd2);
    tick();
    chk("pre_stall", 128'(o_alu_result), 128'(32'd3));
    issue(OP_ADDU, 32'd10, 32'd20);
    i_stall = 1;
    tick();
    chk("stall_hold_res", 128'(o_alu_result), 128'(32'd3));
    chk("stall_hold_valid", 128'(o_valid), 128'(1));
    i_stall = 0;
    tick();
    chk("post_stall", 128'(o_alu_result), 128'(32'd30));
    i_stall = 1; i_flush = 1;
    tick();
    chk("stall_flush_bubble", 128'(obs), 128'(0));
    issue(OP_ADDU, 32'd4, 32'd4);
    tick();
    i_valid = 0;
    tick();
    chk("no_valid_bubble", 128'(obs), 128'(0));
    issue(5'h1F, 32'd4, 32'd4);
    tick();
    chk("unknown_bubble", 128'(obs), 128'(0));

    // Signed multiply.
    run_md(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b0, -1);
    md_ref(OP_MULT, 32'hFFFF_FFFE, 32'h3);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);

`ifdef EX_DIV_EN
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, -1);
    md_ref(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md(OP_DIVU, 32'h1234_5678, 32'h0, 1'b0, -1);
    md_ref(OP_DIVU, 32'h1234_5678, 32'h0);
    read_hilo(32'h1234_5678, 32'hFFFF_FFFF);
`else
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    tick();
    chk("div_off_bubble", 128'(obs), 128'(0));
    chk("div_off_busy", 128'(o_busy), 128'(0));
    idle();
    read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);
`endif

    // Stall held and a flush during RUN do not pause or abort.
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 7);
    md_ref(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hilo(hi_m, lo_m);

    // Reset during RUN aborts and clears HI/LO.
    issue(OP_MULT, 32'd12345, 32'd678);
    tick();
    idle();
    tick(); tick(); tick();
    chk("run_busy", 128'(o_busy), 128'(1));
    i_rst = 1;
    tick();
    chk("rst_run_busy", 128'(o_busy), 128'(0));
    chk("rst_run_exmem", 128'(obs), 128'(0));
    i_rst = 0;
    hi_m = '0; lo_m = '0;
    read_hilo(32'h0, 32'h0);

    // Randomized single-cycle traffic with stalls and flushes.
    idle();
    tick();
    cur = '0;
    for (int i = 0; i < 300; i++) begin
      int k;
      exout_t nxt;
      k = $urandom_range(0, 19);
      if (k < 14)      i_alu_op = 5'(k);
      else if (k < 16) i_alu_op = 5'(16 + k - 14);
      else             i_alu_op = 5'(20 + $urandom_range(0, 11));
      i_valid = ($urandom_range(0, 7) != 0);
      i_stall = ($urandom_range(0, 9) == 0);
      i_flush = ($urandom_range(0, 11) == 0);
      i_pc = $urandom; i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
      if ($urandom_range(0, 7) == 0) i_rt_data = i_rs_data;
      i_mem_fwd_data = $urandom; i_wb_fwd_data = $urandom;
      i_shamt = 5'($urandom_range(0, 31));
      i_rt = 5'($urandom_range(0, 31)); i_rd = 5'($urandom_range(0, 31));
      i_alu_src = 1'($urandom_range(0, 1)); i_reg_dst = 1'($urandom_range(0, 1));
      i_fwd_a_sel = 2'($urandom_range(0, 3)); i_fwd_b_sel = 2'($urandom_range(0, 3));
      i_ctrl_wb = 2'($urandom_range(0, 3)); i_ctrl_m = 3'($urandom_range(0, 7));
      if (i_flush)      nxt = '0;
      else if (i_stall) nxt = cur;
      else if (i_valid) nxt = model_single();
      else              nxt = '0;
      exp_q.push_back(128'(nxt));
      cur = nxt;
      tick();
      chk("rand_single", 128'(obs), exp_q.pop_front());
    end
    idle();

    // Randomized HI/LO traffic.
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
`ifdef EX_DIV_EN
      op = 5'(OP_MULT + $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) op = 5'(OP_DIV + $urandom_range(0, 1));
`else
      op = 5'(OP_MULT + $urandom_range(0, 1));
`endif
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = '0;
      run_md(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 40));
      md_ref(op, a, b);
      read_hilo(hi_m, lo_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
